// File: rtl/lvds_pkg.sv
// Shared constants for the LVDS 7:1 transmitter link sequencer.
package lvds_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_PLL_RST     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK   = 3'd2;
  localparam logic [2:0] ST_LOCK_STABLE = 3'd3;
  localparam logic [2:0] ST_SERDES_RST  = 3'd4;
  localparam logic [2:0] ST_CLK_TRAIN   = 3'd5;
  localparam logic [2:0] ST_RUN         = 3'd6;

  localparam logic [6:0] IDLE_WORD   = 7'b1100011;
  localparam logic [1:0] CLK_PATTERN = 2'b10;

  // A zero cycle count would make a state vanish; every state lasts at least one cycle.
  function automatic int unsigned min1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/lvds_sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
module lvds_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lvds_tx_link_seq.sv
// Start-up / lock-loss recovery sequencer for the dual-channel LVDS 7:1 transmitter.
// state        | meaning
// IDLE         | link disabled, PLL and serializers held in reset
// PLL_RST      | PLL reset pulse
// WAIT_LOCK    | PLL released, waiting for lock (timeout -> retry)
// LOCK_STABLE  | lock must stay high for the full stable window
// SERDES_RST   | lock trusted, serializers still held in reset
// CLK_TRAIN    | clock lane only, data lanes send the idle word
// RUN          | clock and data lanes active, link ready
module lvds_tx_link_seq
  import lvds_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65535,
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned SERDES_RST_CYC   = 32,
  parameter int unsigned CLK_TRAIN_CYC    = 256
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_enable,
  input  logic       I_pll_lock,
  output logic       O_pll_rst,
  output logic       O_serdes_rst,
  output logic       O_clk_lane_en,
  output logic       O_data_lane_en,
  output logic       O_link_ready,
  output logic [7:0] O_retry_cnt,
  output logic [2:0] O_state
);

  localparam int unsigned C_LS = min1(LOCK_STABLE_CYC);
  localparam int unsigned C_TO = min1(LOCK_TIMEOUT_CYC);
  localparam int unsigned C_PR = min1(PLL_RST_CYC);
  localparam int unsigned C_SR = min1(SERDES_RST_CYC);
  localparam int unsigned C_CT = min1(CLK_TRAIN_CYC);
  localparam int unsigned C_M1 = (C_LS > C_TO) ? C_LS : C_TO;
  localparam int unsigned C_M2 = (C_PR > C_SR) ? C_PR : C_SR;
  localparam int unsigned C_M3 = (C_M1 > C_M2) ? C_M1 : C_M2;
  localparam int unsigned C_MAX = (C_M3 > C_CT) ? C_M3 : C_CT;
  localparam int CW = $clog2(C_MAX) + 1;

  localparam logic [CW-1:0] LD_LS  = CW'(C_LS - 1);
  localparam logic [CW-1:0] LD_TO  = CW'(C_TO - 1);
  localparam logic [CW-1:0] LD_PR  = CW'(C_PR - 1);
  localparam logic [CW-1:0] LD_SR  = CW'(C_SR - 1);
  localparam logic [CW-1:0] LD_CT  = CW'(C_CT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          w_lock_s;
  logic [2:0]    w_nxt_state;
  logic [CW-1:0] w_load_val;
  logic          w_retry_inc;
  logic          w_cnt_zero;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_retry;
  logic          r_pll_rst;
  logic          r_serdes_rst;
  logic          r_clk_en;
  logic          r_data_en;
  logic          r_ready;

  lvds_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .i_clk   (I_clk),
    .i_rst_n (I_rst_n),
    .i_d     (I_pll_lock),
    .o_q     (w_lock_s)
  );

  assign w_cnt_zero = (r_cnt == '0);

  // Disable beats lock loss, lock loss beats counter expiry.
  always_comb begin
    w_nxt_state = r_state;
    w_retry_inc = 1'b0;
    if (r_state != ST_IDLE && !I_enable) begin
      w_nxt_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:        if (I_enable) w_nxt_state = ST_PLL_RST;
        ST_PLL_RST:     if (w_cnt_zero) w_nxt_state = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_nxt_state = ST_LOCK_STABLE;
          end else if (w_cnt_zero) begin
            w_nxt_state = ST_PLL_RST;
            w_retry_inc = 1'b1;
          end
        end
        ST_LOCK_STABLE: begin
          if (!w_lock_s) w_nxt_state = ST_WAIT_LOCK;
          else if (w_cnt_zero) w_nxt_state = ST_SERDES_RST;
        end
        ST_SERDES_RST, ST_CLK_TRAIN, ST_RUN: begin
          if (!w_lock_s) begin
            w_nxt_state = ST_PLL_RST;
            w_retry_inc = 1'b1;
          end else if (w_cnt_zero && r_state == ST_SERDES_RST) begin
            w_nxt_state = ST_CLK_TRAIN;
          end else if (w_cnt_zero && r_state == ST_CLK_TRAIN) begin
            w_nxt_state = ST_RUN;
          end
        end
        default:        w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load_val = '0;
    case (w_nxt_state)
      ST_PLL_RST:     w_load_val = LD_PR;
      ST_WAIT_LOCK:   w_load_val = LD_TO;
      ST_LOCK_STABLE: w_load_val = LD_LS;
      ST_SERDES_RST:  w_load_val = LD_SR;
      ST_CLK_TRAIN:   w_load_val = LD_CT;
      default:        w_load_val = '0;
    endcase
  end

  // Outputs are decoded from the next state so they change together with r_state.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_retry      <= 8'd0;
      r_pll_rst    <= 1'b1;
      r_serdes_rst <= 1'b1;
      r_clk_en     <= 1'b0;
      r_data_en    <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if (w_nxt_state != r_state) r_cnt <= w_load_val;
      else if (!w_cnt_zero)       r_cnt <= r_cnt - CNT_ONE;
      if (w_retry_inc && r_retry != 8'hFF) r_retry <= r_retry + 8'd1;
      r_pll_rst    <= (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_PLL_RST);
      r_serdes_rst <= (w_nxt_state != ST_CLK_TRAIN) && (w_nxt_state != ST_RUN);
      r_clk_en     <= (w_nxt_state == ST_CLK_TRAIN) || (w_nxt_state == ST_RUN);
      r_data_en    <= (w_nxt_state == ST_RUN);
      r_ready      <= (w_nxt_state == ST_RUN);
    end
  end

  assign O_pll_rst      = r_pll_rst;
  assign O_serdes_rst   = r_serdes_rst;
  assign O_clk_lane_en  = r_clk_en;
  assign O_data_lane_en = r_data_en;
  assign O_link_ready   = r_ready;
  assign O_retry_cnt    = r_retry;
  assign O_state        = r_state;

endmodule

// File: doc/lvds_tx_link_seq.md
Name: lvds_tx_link_seq

Overview:
- Start-up and recovery sequencer for the dual-channel LVDS 7:1 transmitter.
- Holds the PLL and all OSERDES (clock lane and data lanes) in reset until the PLL lock is stable, then releases them in order: serializer reset, clock lane only, then data lanes.
- Watches for loss of lock and re-runs the sequence on its own.
- Runs on a free-running reference clock that does not depend on the PLL.

Parameters:
- LOCK_STABLE_CYC, 1024: consecutive cycles with lock high before serializer release.
- LOCK_TIMEOUT_CYC, 65535: cycles waiting for lock before a PLL reset retry.
- PLL_RST_CYC, 16: width of the O_pll_rst pulse.
- SERDES_RST_CYC, 32: cycles O_serdes_rst stays asserted after lock is stable.
- CLK_TRAIN_CYC, 256: cycles with only the clock lane enabled before data lanes are enabled.

Ports:
- I_clk  input  1  free-running reference clock.
- I_rst_n  input  1  asynchronous active-low reset.
- I_enable  input  1  software enable for the link; level-sensitive.
- I_pll_lock  input  1  PLL lock, asynchronous to I_clk.
- O_pll_rst  output  1  active-high PLL reset.
- O_serdes_rst  output  1  active-high reset to every OSERDES (clock and data lanes).
- O_clk_lane_en  output  1  gates the 2'b10 pattern onto the clock lane.
- O_data_lane_en  output  1  selects pixel data; when 0 the data lanes send the idle word.
- O_link_ready  output  1  high only in RUN.
- O_retry_cnt  output  8  saturating count of lock timeouts and lock losses.
- O_state  output  3  current state encoding, for debug.

Behaviour:
- Reset is asynchronous, active-low; clock is I_clk only. Reset values:
  - state IDLE
  - O_pll_rst=1, O_serdes_rst=1
  - O_clk_lane_en=0, O_data_lane_en=0, O_link_ready=0
  - O_retry_cnt=0
  - counter=0, sync flops=0
- I_pll_lock passes through a 2-FF synchronizer (lock_s); lock_s lags I_pll_lock by 2 cycles.
- One shared down-counter, width $clog2 of the largest parameter plus 1. It is loaded on every state entry; "expires" means it reaches 0.
- States (O_state code):
  - IDLE (0): O_pll_rst=1, O_serdes_rst=1. I_enable=1 -> PLL_RST.
  - PLL_RST (1): O_pll_rst=1 for PLL_RST_CYC cycles -> WAIT_LOCK.
  - WAIT_LOCK (2): O_pll_rst=0, O_serdes_rst=1.
    - lock_s=1 -> LOCK_STABLE.
    - Counter expires after LOCK_TIMEOUT_CYC -> O_retry_cnt+1, then PLL_RST.
  - LOCK_STABLE (3): counts LOCK_STABLE_CYC.
    - lock_s=0 at any point -> WAIT_LOCK with the timeout counter reloaded; no retry increment (glitch before stable).
    - Counter expires -> SERDES_RST.
  - SERDES_RST (4): O_serdes_rst=1 for SERDES_RST_CYC cycles -> CLK_TRAIN.
  - CLK_TRAIN (5): O_serdes_rst=0, O_clk_lane_en=1, O_data_lane_en=0 for CLK_TRAIN_CYC cycles -> RUN.
  - RUN (6): O_clk_lane_en=1, O_data_lane_en=1, O_link_ready=1.
- Lock loss: lock_s=0 in SERDES_RST, CLK_TRAIN or RUN ->
  - next cycle O_serdes_rst=1 and all enables=0 (registered outputs, 1-cycle latency);
  - O_retry_cnt+1;
  - go to PLL_RST.
- I_enable=0 in any state except IDLE -> IDLE on the next cycle with reset-state outputs. O_retry_cnt is held.
- Priority when events coincide: I_enable=0 > lock loss > counter expiry.
- O_retry_cnt saturates at 255; it is cleared only by I_rst_n.
- All outputs are registered and glitch-free. Enables never rise while O_serdes_rst=1.
- Reset asserted mid-sequence forces the reset values immediately (asynchronously).
- Parameter rule: a parameter value of 0 is treated as 1 (minimum one cycle per state).

Decomposition:
- Package lvds_pkg holds:
  - state enum constants ST_IDLE..ST_RUN (3-bit);
  - idle-word constant 7'b1100011;
  - clock pattern 2'b10.
- Sub-module lvds_sync2 is the generic 2-FF synchronizer with a reset value parameter, reused for I_pll_lock.
- Counter and FSM stay in lvds_tx_link_seq.

Test Plan:
All scenarios use LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=50, PLL_RST_CYC=4, SERDES_RST_CYC=4, CLK_TRAIN_CYC=10.
- Nominal bring-up: I_rst_n release, I_enable=1, lock rises at cycle 20 -> O_pll_rst low after 4 cycles; O_serdes_rst falls 2+8+4 cycles after lock; O_clk_lane_en precedes O_data_lane_en by exactly 10 cycles; O_link_ready=1; O_retry_cnt=0.
- Lock never arrives: lock held 0 -> O_pll_rst pulses 4 cycles every 54 cycles; O_retry_cnt=3 after 3 timeouts; serdes stays in reset.
- Glitch before stable: lock high 5 cycles, low 1 cycle, then high -> return to WAIT_LOCK; O_retry_cnt stays 0; stable count restarts and full bring-up follows.
- Lock loss in RUN: drop lock -> 3 cycles later O_serdes_rst=1 and O_link_ready=0; O_retry_cnt=1; re-sequence completes once lock returns.
- I_enable=0 in CLK_TRAIN while lock drops in the same cycle -> IDLE, O_retry_cnt unchanged; I_enable=1 restarts from PLL_RST.
- Saturation and reset: force 300 lock losses -> O_retry_cnt=255; asynchronous I_rst_n mid-RUN -> all outputs at reset values within the same cycle.
